// File: rtl/rvh_l1d_ld_wb_buf_if.sv
`default_nettype none
// ============================================================================
// Module : rvh_l1d_ld_wb_buf_if
// Bundles the bank-response, integer-writeback and PTW channels of the buffer.
// Rev    : 1.0
// ============================================================================
interface rvh_l1d_ld_wb_buf_if #(
  parameter int N_IN       = 2,
  parameter int N_WB       = 1,
  parameter int XLEN       = 64,
  parameter int SEG_W      = 128,
  parameter int ROB_TAG_W  = 6,
  parameter int PREG_TAG_W = 7,
  parameter int PTW_ID_W   = 6
);
  localparam int OFF_W = $clog2(SEG_W / 8);

  logic [N_IN-1:0]                 in_vld_i;
  logic                            in_rdy_o;
  logic [N_IN-1:0][SEG_W-1:0]      in_seg_i;
  logic [N_IN-1:0][OFF_W-1:0]      in_off_i;
  logic [N_IN-1:0][1:0]            in_size_i;
  logic [N_IN-1:0]                 in_unsigned_i;
  logic [N_IN-1:0]                 in_is_ptw_i;
  logic [N_IN-1:0]                 in_from_mlfb_i;
  logic [N_IN-1:0][ROB_TAG_W-1:0]  in_rob_tag_i;
  logic [N_IN-1:0][PREG_TAG_W-1:0] in_prd_i;

  logic [N_WB-1:0]                 wb_vld_o;
  logic [N_WB-1:0]                 wb_rdy_i;
  logic [N_WB-1:0][ROB_TAG_W-1:0]  wb_rob_tag_o;
  logic [N_WB-1:0][PREG_TAG_W-1:0] wb_prd_o;
  logic [N_WB-1:0][XLEN-1:0]       wb_data_o;
  logic [N_WB-1:0]                 wb_from_mlfb_o;

  logic                            ptw_vld_o;
  logic                            ptw_rdy_i;
  logic [PTW_ID_W-1:0]             ptw_id_o;
  logic [XLEN-1:0]                 ptw_pte_o;

  modport slave (
    input  in_vld_i, in_seg_i, in_off_i, in_size_i, in_unsigned_i,
           in_is_ptw_i, in_from_mlfb_i, in_rob_tag_i, in_prd_i,
    output in_rdy_o,
    output wb_vld_o, wb_rob_tag_o, wb_prd_o, wb_data_o, wb_from_mlfb_o,
    input  wb_rdy_i,
    output ptw_vld_o, ptw_id_o, ptw_pte_o,
    input  ptw_rdy_i
  );

  modport master (
    output in_vld_i, in_seg_i, in_off_i, in_size_i, in_unsigned_i,
           in_is_ptw_i, in_from_mlfb_i, in_rob_tag_i, in_prd_i,
    input  in_rdy_o,
    input  wb_vld_o, wb_rob_tag_o, wb_prd_o, wb_data_o, wb_from_mlfb_o,
    output wb_rdy_i,
    input  ptw_vld_o, ptw_id_o, ptw_pte_o,
    output ptw_rdy_i
  );
endinterface
`default_nettype wire

// File: rtl/rvh_l1d_ld_wb_buf.sv
`default_nettype none
// ============================================================================
// Module : rvh_l1d_ld_wb_buf
// In-order load-writeback FIFO: extracts/extends load data at enqueue and
// drains it through N_WB writeback ports plus one PTW port.
// Rev    : 1.0
// ============================================================================
module rvh_l1d_ld_wb_buf #(
  parameter int N_IN       = 2,
  parameter int N_WB       = 1,
  parameter int DEPTH      = 8,
  parameter int XLEN       = 64,
  parameter int SEG_W      = 128,
  parameter int ROB_TAG_W  = 6,
  parameter int PREG_TAG_W = 7,
  parameter int PTW_ID_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  rvh_l1d_ld_wb_buf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]       ent_data_q [DEPTH];
  logic [XLEN-1:0]       ent_data_d [DEPTH];
  logic [ROB_TAG_W-1:0]  ent_rob_q  [DEPTH];
  logic [ROB_TAG_W-1:0]  ent_rob_d  [DEPTH];
  logic [PREG_TAG_W-1:0] ent_prd_q  [DEPTH];
  logic [PREG_TAG_W-1:0] ent_prd_d  [DEPTH];
  logic [DEPTH-1:0]      ent_mlfb_q, ent_mlfb_d;
  logic [DEPTH-1:0]      ent_ptw_q,  ent_ptw_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  in_rdy;
  logic [XLEN-1:0]       raw      [N_IN];
  logic [XLEN-1:0]       ext_data [N_IN];
  logic [CNT_W-1:0]      enq_cnt;
  logic [CNT_W-1:0]      deq_cnt;
  logic [PTR_W-1:0]      slot;
  logic [N_WB-1:0]       wb_vld;
  logic [PTR_W-1:0]      wb_idx [N_WB];
  logic                  wb_prev;
  logic                  wb_run;
  logic                  ptw_vld;

  // Ready looks only at the registered occupancy, never at this cycle's drain.
  assign in_rdy = (CNT_W'(DEPTH) - count_q) >= CNT_W'(N_IN);

  always_comb begin
    for (int c = 0; c < N_IN; c++) begin
      raw[c]      = XLEN'(bus.in_seg_i[c] >> {bus.in_off_i[c], 3'b000});
      ext_data[c] = raw[c];
      if (!bus.in_is_ptw_i[c]) begin
        case (bus.in_size_i[c])
          2'd0:    ext_data[c] = {{(XLEN-8){~bus.in_unsigned_i[c] & raw[c][7]}},   raw[c][7:0]};
          2'd1:    ext_data[c] = {{(XLEN-16){~bus.in_unsigned_i[c] & raw[c][15]}}, raw[c][15:0]};
          2'd2:    ext_data[c] = {{(XLEN-32){~bus.in_unsigned_i[c] & raw[c][31]}}, raw[c][31:0]};
          default: ext_data[c] = raw[c];
        endcase
      end
    end
  end

  // Accepted channels pack into consecutive slots from tail, lowest index first.
  always_comb begin
    ent_data_d = ent_data_q;
    ent_rob_d  = ent_rob_q;
    ent_prd_d  = ent_prd_q;
    ent_mlfb_d = ent_mlfb_q;
    ent_ptw_d  = ent_ptw_q;
    enq_cnt    = '0;
    slot       = tail_q;
    for (int c = 0; c < N_IN; c++) begin
      if (bus.in_vld_i[c] && in_rdy && !flush_i) begin
        slot             = tail_q + enq_cnt[PTR_W-1:0];
        ent_data_d[slot] = ext_data[c];
        ent_rob_d[slot]  = bus.in_rob_tag_i[c];
        ent_prd_d[slot]  = bus.in_prd_i[c];
        ent_mlfb_d[slot] = bus.in_from_mlfb_i[c];
        ent_ptw_d[slot]  = bus.in_is_ptw_i[c];
        enq_cnt          = enq_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    wb_vld  = '0;
    wb_prev = 1'b1;
    wb_run  = 1'b1;
    deq_cnt = '0;
    for (int k = 0; k < N_WB; k++) begin
      wb_idx[k] = head_q + PTR_W'(k);
      wb_vld[k] = wb_prev && (count_q > CNT_W'(k)) && !ent_ptw_q[wb_idx[k]];
      wb_prev   = wb_vld[k];
      // Only the unbroken prefix of handshakes retires; later fires are ignored.
      if (wb_run && wb_vld[k] && bus.wb_rdy_i[k]) begin
        deq_cnt = deq_cnt + CNT_W'(1);
      end else begin
        wb_run = 1'b0;
      end
    end
    ptw_vld = (count_q != '0) && ent_ptw_q[head_q];
    if (ptw_vld && bus.ptw_rdy_i) begin
      deq_cnt = CNT_W'(1);
    end
  end

  always_comb begin
    head_d  = head_q + deq_cnt[PTR_W-1:0];
    tail_d  = tail_q + enq_cnt[PTR_W-1:0];
    count_d = count_q + enq_cnt - deq_cnt;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ent_mlfb_q <= '0;
      ent_ptw_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_data_q[i] <= '0;
        ent_rob_q[i]  <= '0;
        ent_prd_q[i]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_mlfb_q <= ent_mlfb_d;
      ent_ptw_q  <= ent_ptw_d;
      ent_data_q <= ent_data_d;
      ent_rob_q  <= ent_rob_d;
      ent_prd_q  <= ent_prd_d;
    end
  end

  assign bus.in_rdy_o = in_rdy;
  assign bus.wb_vld_o = wb_vld;

  for (genvar k = 0; k < N_WB; k++) begin : g_wb_port
    assign bus.wb_data_o[k]      = ent_data_q[wb_idx[k]];
    assign bus.wb_rob_tag_o[k]   = ent_rob_q[wb_idx[k]];
    assign bus.wb_prd_o[k]       = ent_prd_q[wb_idx[k]];
    assign bus.wb_from_mlfb_o[k] = ent_mlfb_q[wb_idx[k]];
  end

  // The ROB tag field doubles as the PTW request id.
  assign bus.ptw_vld_o = ptw_vld;
  assign bus.ptw_id_o  = PTW_ID_W'(ent_rob_q[head_q]);
  assign bus.ptw_pte_o = ent_data_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_rvh_l1d_ld_wb_buf.sv
`default_nettype none
// ============================================================================
// Module : tb_rvh_l1d_ld_wb_buf
// Directed stimulus with a queue scoreboard checked by a separate monitor.
// Rev    : 1.0
// ============================================================================
module tb_rvh_l1d_ld_wb_buf;
  localparam int N_IN       = 2;
  localparam int N_WB       = 2;
  localparam int DEPTH      = 8;
  localparam int XLEN       = 64;
  localparam int SEG_W      = 128;
  localparam int ROB_TAG_W  = 6;
  localparam int PREG_TAG_W = 7;
  localparam int PTW_ID_W   = 6;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  rob;
    logic [6:0]  prd;
    logic        mlfb;
    logic        ptw;
  } exp_t;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_run;
  exp_t exp_q [$];
  exp_t ch_exp [N_IN];

  rvh_l1d_ld_wb_buf_if #(
    .N_IN(N_IN), .N_WB(N_WB), .XLEN(XLEN), .SEG_W(SEG_W),
    .ROB_TAG_W(ROB_TAG_W), .PREG_TAG_W(PREG_TAG_W), .PTW_ID_W(PTW_ID_W)
  ) bus ();

  rvh_l1d_ld_wb_buf #(
    .N_IN(N_IN), .N_WB(N_WB), .DEPTH(DEPTH), .XLEN(XLEN), .SEG_W(SEG_W),
    .ROB_TAG_W(ROB_TAG_W), .PREG_TAG_W(PREG_TAG_W), .PTW_ID_W(PTW_ID_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int k);
    exp_t x;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_err++;
      $display("FAIL unexpected_drain: port %0d retired an entry, got 1 expected 0 pending", k);
    end else begin
      x = exp_q.pop_front();
      if (k < 0) begin
        chk("ptw_entry_kind", 64'(x.ptw), 64'd1);
        chk("ptw_id", 64'(bus.ptw_id_o), 64'(x.rob));
        chk("ptw_pte", bus.ptw_pte_o, x.data);
      end else begin
        chk("wb_entry_kind", 64'(x.ptw), 64'd0);
        chk("wb_data", bus.wb_data_o[k], x.data);
        chk("wb_rob_tag", 64'(bus.wb_rob_tag_o[k]), 64'(x.rob));
        chk("wb_prd", 64'(bus.wb_prd_o[k]), 64'(x.prd));
        chk("wb_from_mlfb", 64'(bus.wb_from_mlfb_o[k]), 64'(x.mlfb));
      end
    end
  endtask

  // Monitor: retire pops first (entries already stored), then record new enqueues.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (bus.ptw_vld_o) begin
        chk("ptw_excludes_wb", 64'(bus.wb_vld_o), 64'd0);
        if (bus.ptw_rdy_i) pop_cmp(-1);
      end
      mon_run = 1'b1;
      for (int k = 0; k < N_WB; k++) begin
        if (mon_run && bus.wb_vld_o[k] && bus.wb_rdy_i[k]) pop_cmp(k);
        else mon_run = 1'b0;
      end
      if (bus.in_rdy_o) begin
        for (int c = 0; c < N_IN; c++) begin
          if (bus.in_vld_i[c]) exp_q.push_back(ch_exp[c]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [127:0] seg, input logic [3:0] off,
                       input logic [1:0] size, input logic uns, input logic ptw,
                       input logic mlfb, input logic [5:0] rob, input logic [6:0] prd,
                       input logic [63:0] exp);
    bus.in_vld_i[c]       = 1'b1;
    bus.in_seg_i[c]       = seg;
    bus.in_off_i[c]       = off;
    bus.in_size_i[c]      = size;
    bus.in_unsigned_i[c]  = uns;
    bus.in_is_ptw_i[c]    = ptw;
    bus.in_from_mlfb_i[c] = mlfb;
    bus.in_rob_tag_i[c]   = rob;
    bus.in_prd_i[c]       = prd;
    ch_exp[c] = '{data: exp, rob: rob, prd: prd, mlfb: mlfb, ptw: ptw};
  endtask

  task automatic idle();
    bus.in_vld_i = '0;
  endtask

  task automatic drain();
    int n = 0;
    bus.wb_rdy_i  = '1;
    bus.ptw_rdy_i = 1'b1;
    while (exp_q.size() != 0 && n < 40) begin
      step(1);
      n++;
    end
    bus.wb_rdy_i  = '0;
    bus.ptw_rdy_i = 1'b0;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    chk("drain_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_vld_i       = '0;
    bus.in_seg_i       = '0;
    bus.in_off_i       = '0;
    bus.in_size_i      = '0;
    bus.in_unsigned_i  = '0;
    bus.in_is_ptw_i    = '0;
    bus.in_from_mlfb_i = '0;
    bus.in_rob_tag_i   = '0;
    bus.in_prd_i       = '0;
    bus.wb_rdy_i       = '0;
    bus.ptw_rdy_i      = 1'b0;
    rst = 1'b1;
    step(2);
    chk("rst_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    chk("rst_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
    chk("rst_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    chk("rst_wb_data", bus.wb_data_o[0], 64'd0);
    chk("rst_ptw_pte", bus.ptw_pte_o, 64'd0);
    rst = 1'b0;
    step(1);

    // Signed / unsigned byte at offset 1
    drive(0, 128'h8000, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 6'd3, 7'd9, 64'hFFFF_FFFF_FFFF_FF80);
    step(1); idle();
    chk("byte_s_wb_vld", 64'(bus.wb_vld_o), 64'd1);
    bus.wb_rdy_i = 2'b01; step(1); bus.wb_rdy_i = '0;
    chk("byte_s_empty", 64'(bus.wb_vld_o), 64'd0);
    drive(0, 128'h8000, 4'd1, 2'd0, 1'b1, 1'b0, 1'b0, 6'd3, 7'd9, 64'h80);
    step(1); idle();
    drain();

    // Zero fill past segment end, plus unsigned half on channel 1
    drive(0, {32'hDEAD_BEEF, 96'h0}, 4'd12, 2'd3, 1'b0, 1'b0, 1'b1, 6'd5, 7'd17, 64'h0000_0000_DEAD_BEEF);
    drive(1, 128'hBEEF_0000, 4'd2, 2'd1, 1'b1, 1'b0, 1'b0, 6'd6, 7'd18, 64'hBEEF);
    step(1); idle();
    chk("pair_wb_vld", 64'(bus.wb_vld_o), 64'd3);
    bus.wb_rdy_i = 2'b11; step(1); bus.wb_rdy_i = '0;
    chk("pair_empty", 64'(bus.wb_vld_o), 64'd0);

    // Channel 1 alone (gap compression), then both; partial-prefix handshakes
    drive(1, 128'hCAFE_F00D_0000_0000, 4'd4, 2'd2, 1'b1, 1'b0, 1'b1, 6'd8, 7'd20, 64'hCAFE_F00D);
    step(1); idle();
    drive(0, 128'h8765_4321, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0, 6'd7, 7'd19, 64'hFFFF_FFFF_8765_4321);
    drive(1, {16'h8001, 112'h0}, 4'd14, 2'd1, 1'b0, 1'b0, 1'b0, 6'd9, 7'd21, 64'hFFFF_FFFF_FFFF_8001);
    step(1); idle();
    bus.wb_rdy_i = 2'b10; step(1);
    chk("rdy10_wb_vld", 64'(bus.wb_vld_o), 64'd3);
    bus.wb_rdy_i = 2'b01; step(1);
    bus.wb_rdy_i = 2'b11; step(1); bus.wb_rdy_i = '0;
    chk("prefix_empty", 64'(bus.wb_vld_o), 64'd0);

    // Fill to 7 with no drain: ready must drop and only recover after a retire
    for (int i = 0; i < 3; i++) begin
      drive(0, 128'(64'h100 + 2 * i), 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'(2 * i), 7'(2 * i), 64'h100 + 64'(2 * i));
      drive(1, 128'(64'h101 + 2 * i), 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'(2 * i + 1), 7'(2 * i + 1), 64'h101 + 64'(2 * i));
      step(1);
    end
    idle();
    chk("fill6_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    drive(0, 128'h106, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd6, 7'd6, 64'h106);
    step(1); idle();
    chk("fill7_in_rdy", 64'(bus.in_rdy_o), 64'd0);
    drive(0, 128'h107, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd7, 7'd7, 64'h107);
    drive(1, 128'h108, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd8, 7'd8, 64'h108);
    bus.wb_rdy_i = 2'b10; step(1);
    chk("full_rdy10_in_rdy", 64'(bus.in_rdy_o), 64'd0);
    chk("full_rdy10_wb_vld", 64'(bus.wb_vld_o), 64'd3);
    bus.wb_rdy_i = 2'b01;
    chk("deq_cycle_in_rdy", 64'(bus.in_rdy_o), 64'd0);
    step(1); bus.wb_rdy_i = '0;
    chk("after_deq_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    step(1); idle();
    chk("full8_in_rdy", 64'(bus.in_rdy_o), 64'd0);
    drain();

    // PTW entry between two integer loads blocks the writeback ports
    drive(0, 128'h1111, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd10, 7'd30, 64'h1111);
    drive(1, 128'h8000_0000_0000_1003, 4'd0, 2'd0, 1'b0, 1'b1, 1'b0, 6'h2A, 7'd31, 64'h8000_0000_0000_1003);
    step(1); idle();
    drive(0, 128'hFFFF_FFFF, 4'd0, 2'd2, 1'b1, 1'b0, 1'b1, 6'd12, 7'd32, 64'hFFFF_FFFF);
    step(1); idle();
    chk("ptwmix_wb_vld", 64'(bus.wb_vld_o), 64'd1);
    chk("ptwmix_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
    bus.wb_rdy_i = 2'b11; step(1); bus.wb_rdy_i = '0;
    chk("ptwhead_ptw_vld", 64'(bus.ptw_vld_o), 64'd1);
    chk("ptwhead_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    chk("ptwhead_id", 64'(bus.ptw_id_o), 64'h2A);
    bus.ptw_rdy_i = 1'b1; step(1); bus.ptw_rdy_i = 1'b0;
    chk("after_ptw_wb_vld", 64'(bus.wb_vld_o), 64'd1);
    chk("after_ptw_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
    drain();

    // Flush with five entries buffered and both channels enqueuing
    for (int i = 0; i < 2; i++) begin
      drive(0, 128'(64'h200 + i), 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd1, 7'd1, 64'h200 + 64'(i));
      drive(1, 128'(64'h210 + i), 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd2, 7'd2, 64'h210 + 64'(i));
      step(1);
    end
    idle();
    drive(0, 128'h220, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd3, 7'd3, 64'h220);
    step(1);
    drive(1, 128'h230, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd4, 7'd4, 64'h230);
    flush = 1'b1;
    chk("preflush_wb_vld", 64'(bus.wb_vld_o), 64'd3);
    step(1); flush = 1'b0; idle();
    chk("flush_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    chk("flush_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
    chk("flush_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    drive(1, 128'h5A00, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 6'd11, 7'd40, 64'h5A);
    step(1); idle();
    drain();

    // Reset mid-stream with a PTW entry at the head
    drive(0, 128'h300, 4'd0, 2'd3, 1'b0, 1'b1, 1'b0, 6'd13, 7'd13, 64'h300);
    drive(1, 128'h301, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 6'd14, 7'd14, 64'h301);
    step(1);
    rst = 1'b1;
    bus.wb_rdy_i = 2'b11;
    step(1); rst = 1'b0; idle(); bus.wb_rdy_i = '0;
    chk("rst_mid_wb_vld", 64'(bus.wb_vld_o), 64'd0);
    chk("rst_mid_ptw_vld", 64'(bus.ptw_vld_o), 64'd0);
    chk("rst_mid_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    chk("rst_mid_ptw_pte", bus.ptw_pte_o, 64'd0);
    drive(0, 128'h7FFF_0000, 4'd2, 2'd1, 1'b0, 1'b0, 1'b1, 6'd15, 7'd50, 64'h7FFF);
    step(1); idle();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
